// File: rtl/vi_cpu_core.sv
// Single-cycle RV32I-subset core with a private unified 128-bit-line memory.
// One instruction retires per rising clock edge; illegal or misaligned ops trap to EXC_PC.
module vi_cpu_core #(
  parameter logic [31:0] BOOT_PC   = 32'h0000_1000,
  parameter logic [31:0] EXC_PC    = 32'h0000_2000,
  parameter int          MEM_LINES = 128
) (
  input  logic clk_i,
  input  logic rsn_i
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]  pc_r;
  logic [31:0]  epc_r;
  logic [31:0]  cause_r;
  logic [31:0]  regs_r [0:31];
  logic [127:0] mem_r  [0:MEM_LINES-1];

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] rs1_v_s;
  logic [31:0] rs2_v_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_u_s;
  logic [31:0] addr_s;
  logic [31:0] ld_data_s;
  logic [31:0] pc_plus4_s;

  logic        illegal_s;
  logic        acc_fault_s;
  logic [31:0] acc_cause_s;
  logic        jump_s;
  logic [31:0] target_s;
  logic        rd_we_s;
  logic [31:0] rd_val_s;
  logic        st_en_s;
  logic        trap_s;
  logic [31:0] trap_cause_s;
  logic [31:0] next_pc_s;
  logic        reg_we_s;
  logic        mem_we_s;
  logic        unused_s;

  // Line = addr[13:7], word = addr[3:2]; remaining address bits alias.
  assign instr_s    = mem_r[pc_r[13:7]][{pc_r[3:2], 5'b00000} +: 32];
  assign opcode_s   = instr_s[6:0];
  assign rd_s       = instr_s[11:7];
  assign funct3_s   = instr_s[14:12];
  assign rs1_s      = instr_s[19:15];
  assign rs2_s      = instr_s[24:20];
  assign funct7_s   = instr_s[31:25];
  assign rs1_v_s    = (rs1_s == 5'd0) ? 32'h0 : regs_r[rs1_s];
  assign rs2_v_s    = (rs2_s == 5'd0) ? 32'h0 : regs_r[rs2_s];
  assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  assign imm_u_s    = {instr_s[31:12], 12'h000};
  assign pc_plus4_s = pc_r + 32'd4;
  assign addr_s     = rs1_v_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
  assign ld_data_s  = mem_r[addr_s[13:7]][{addr_s[3:2], 5'b00000} +: 32];
  assign unused_s   = ^{addr_s[31:14], addr_s[6:4]};

  // Instruction decode and execute: result, memory request and raw control-flow target.
  always_comb begin
    illegal_s   = 1'b0;
    acc_fault_s = 1'b0;
    acc_cause_s = 32'd0;
    jump_s      = 1'b0;
    target_s    = 32'h0;
    rd_we_s     = 1'b0;
    rd_val_s    = 32'h0;
    st_en_s     = 1'b0;
    case (opcode_s)
      OP_REG: begin
        rd_we_s = 1'b1;
        case ({funct7_s, funct3_s})
          {7'b0000000, 3'b000}: rd_val_s = rs1_v_s + rs2_v_s;
          {7'b0100000, 3'b000}: rd_val_s = rs1_v_s - rs2_v_s;
          {7'b0000000, 3'b111}: rd_val_s = rs1_v_s & rs2_v_s;
          {7'b0000000, 3'b110}: rd_val_s = rs1_v_s | rs2_v_s;
          {7'b0000000, 3'b100}: rd_val_s = rs1_v_s ^ rs2_v_s;
          {7'b0000000, 3'b010}: rd_val_s = {31'h0, $signed(rs1_v_s) < $signed(rs2_v_s)};
          default:              illegal_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        rd_we_s   = 1'b1;
        rd_val_s  = rs1_v_s + imm_i_s;
        illegal_s = (funct3_s != 3'b000);
      end
      OP_LUI: begin
        rd_we_s  = 1'b1;
        rd_val_s = imm_u_s;
      end
      OP_LOAD: begin
        rd_we_s     = 1'b1;
        rd_val_s    = ld_data_s;
        illegal_s   = (funct3_s != 3'b010);
        acc_fault_s = (addr_s[1:0] != 2'b00);
        acc_cause_s = 32'd4;
      end
      OP_STORE: begin
        st_en_s     = 1'b1;
        illegal_s   = (funct3_s != 3'b010);
        acc_fault_s = (addr_s[1:0] != 2'b00);
        acc_cause_s = 32'd6;
      end
      OP_BRANCH: begin
        target_s = pc_r + imm_b_s;
        case (funct3_s)
          3'b000:  jump_s = (rs1_v_s == rs2_v_s);
          3'b001:  jump_s = (rs1_v_s != rs2_v_s);
          default: illegal_s = 1'b1;
        endcase
      end
      OP_JAL: begin
        jump_s   = 1'b1;
        target_s = pc_r + imm_j_s;
        rd_we_s  = 1'b1;
        rd_val_s = pc_plus4_s;
      end
      OP_JALR: begin
        jump_s    = 1'b1;
        target_s  = (rs1_v_s + imm_i_s) & 32'hFFFF_FFFE;
        rd_we_s   = 1'b1;
        rd_val_s  = pc_plus4_s;
        illegal_s = (funct3_s != 3'b000);
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Trap resolution: illegal beats access fault beats misaligned taken target.
  always_comb begin
    trap_s       = 1'b0;
    trap_cause_s = 32'd0;
    next_pc_s    = pc_plus4_s;
    if (illegal_s || $isunknown(instr_s)) begin
      trap_s       = 1'b1;
      trap_cause_s = 32'd2;
    end else if (acc_fault_s) begin
      trap_s       = 1'b1;
      trap_cause_s = acc_cause_s;
    end else if (jump_s && (target_s[1:0] != 2'b00)) begin
      trap_s       = 1'b1;
      trap_cause_s = 32'd0;
    end else if (jump_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  assign reg_we_s = rd_we_s && !trap_s && (rd_s != 5'd0);
  assign mem_we_s = st_en_s && !trap_s;

  // Architectural state: pc, trap CSRs and register file.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pc_r    <= BOOT_PC;
      epc_r   <= 32'h0;
      cause_r <= 32'h0;
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0;
      end
    end else if (trap_s) begin
      epc_r   <= pc_r;
      cause_r <= trap_cause_s;
      pc_r    <= EXC_PC;
    end else begin
      pc_r <= next_pc_s;
      if (reg_we_s) begin
        regs_r[rd_s] <= rd_val_s;
      end
    end
  end

  // Store port; contents survive reset, but no store retires while reset is held.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (rsn_i && mem_we_s) begin
      mem_r[addr_s[13:7]][{addr_s[3:2], 5'b00000} +: 32] <= rs2_v_s;
    end
  end

endmodule

// File: tb/tb_vi_cpu_core.sv
// Directed bench for vi_cpu_core: programs are poked into the memory array,
// results are read back through the register file, pc and trap registers.
module tb_vi_cpu_core;

  logic clk_i;
  logic rsn_i;
  int   errors;
  int   checks;

  vi_cpu_core dut (
    .clk_i (clk_i),
    .rsn_i (rsn_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(7'b0000011, 3'b010, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(7'b1100111, 3'b000, rd, rs1, imm);
  endfunction

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic load_line(input logic [6:0] idx, input logic [31:0] w3, input logic [31:0] w2,
                           input logic [31:0] w1, input logic [31:0] w0);
    dut.mem_r[idx] = {w3, w2, w1, w0};
  endtask

  // Reset held across one edge, then the new program at 0x1000 is loaded and reset released.
  task automatic restart(input logic [31:0] w3, input logic [31:0] w2, input logic [31:0] w1, input logic [31:0] w0);
    rsn_i = 1'b0;
    tick(1);
    load_line(7'h20, w3, w2, w1, w0);
    rsn_i = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rsn_i  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      dut.mem_r[i] = 128'h0;
    end
    load_line(7'h20, enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2),
                     enc_r(7'b0100000, 3'b000, 5'd4, 5'd1, 5'd2),
                     addi(5'd2, 5'd0, 12'd5),
                     addi(5'd1, 5'd0, 12'd7));
    #20;
    rsn_i = 1'b1;
    #1;
    chk("boot_pc", dut.pc_r, 32'h0000_1000);
    chk("boot_epc", dut.epc_r, 32'h0);
    chk("boot_cause", dut.cause_r, 32'h0);
    for (int r = 1; r < 32; r++) begin
      chk($sformatf("boot_x%0d", r), dut.regs_r[r], 32'h0);
    end

    tick(1);
    chk("alu_first_x1", dut.regs_r[1], 32'd7);
    chk("alu_first_pc", dut.pc_r, 32'h0000_1004);
    tick(3);
    chk("alu_x2", dut.regs_r[2], 32'd5);
    chk("alu_add_x3", dut.regs_r[3], 32'd12);
    chk("alu_sub_x4", dut.regs_r[4], 32'd2);
    chk("alu_pc", dut.pc_r, 32'h0000_1010);

    // Asynchronous reset between edges.
    #3;
    rsn_i = 1'b0;
    #1;
    chk("areset_pc", dut.pc_r, 32'h0000_1000);
    chk("areset_x1", dut.regs_r[1], 32'h0);
    chk("areset_x3", dut.regs_r[3], 32'h0);
    chk("areset_mem", dut.mem_r[7'h20][31:0], addi(5'd1, 5'd0, 12'd7));
    tick(1);
    chk("held_pc", dut.pc_r, 32'h0000_1000);
    chk("held_x1", dut.regs_r[1], 32'h0);

    // Signed compare and xor.
    restart(enc_r(7'b0000000, 3'b100, 5'd8, 5'd5, 5'd6),
            enc_r(7'b0000000, 3'b010, 5'd7, 5'd0, 5'd5),
            enc_r(7'b0000000, 3'b010, 5'd6, 5'd5, 5'd0),
            addi(5'd5, 5'd0, 12'hFFF));
    tick(4);
    chk("addi_neg_x5", dut.regs_r[5], 32'hFFFF_FFFF);
    chk("slt_neg_x6", dut.regs_r[6], 32'd1);
    chk("slt_pos_x7", dut.regs_r[7], 32'd0);
    chk("xor_x8", dut.regs_r[8], 32'hFFFF_FFFE);

    // LUI and wraparound.
    restart(enc_r(7'b0000000, 3'b110, 5'd11, 5'd9, 5'd10),
            addi(5'd10, 5'd9, 12'd1),
            addi(5'd9, 5'd9, 12'hFFF),
            {20'h80000, 5'd9, 7'b0110111});
    tick(4);
    chk("lui_addi_x9", dut.regs_r[9], 32'h7FFF_FFFF);
    chk("wrap_x10", dut.regs_r[10], 32'h8000_0000);
    chk("or_x11", dut.regs_r[11], 32'hFFFF_FFFF);

    // Store then load; neighbouring words untouched.
    load_line(7'h00, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111);
    restart(lw(5'd12, 5'd0, 12'd4), lw(5'd7, 5'd0, 12'd0),
            enc_sw(5'd1, 5'd0, 12'd0), addi(5'd1, 5'd0, 12'd7));
    tick(4);
    chk("lw_x7", dut.regs_r[7], 32'd7);
    chk("lw_word1_x12", dut.regs_r[12], 32'h2222_2222);
    chk("sw_line0", dut.mem_r[7'h00], {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h0000_0007});

    // Misaligned load traps without writing x7.
    restart(32'h0, 32'h0, lw(5'd7, 5'd0, 12'd2), addi(5'd7, 5'd0, 12'd9));
    tick(2);
    chk("lw_mis_x7", dut.regs_r[7], 32'd9);
    chk("lw_mis_pc", dut.pc_r, 32'h0000_2000);
    chk("lw_mis_cause", dut.cause_r, 32'd4);
    chk("lw_mis_epc", dut.epc_r, 32'h0000_1004);
    tick(1);
    chk("handler_cause", dut.cause_r, 32'd2);
    chk("handler_epc", dut.epc_r, 32'h0000_2000);

    // Misaligned store traps without writing memory.
    restart(32'h0, 32'h0, enc_sw(5'd1, 5'd0, 12'd1), addi(5'd1, 5'd0, 12'd5));
    tick(2);
    chk("sw_mis_cause", dut.cause_r, 32'd6);
    chk("sw_mis_epc", dut.epc_r, 32'h0000_1004);
    chk("sw_mis_pc", dut.pc_r, 32'h0000_2000);
    chk("sw_mis_mem", dut.mem_r[7'h00][31:0], 32'd7);

    // BNE not taken, then JAL.
    restart(32'h0, 32'h0, enc_jal(5'd1, 21'd16), enc_b(3'b001, 5'd0, 5'd0, 13'd8));
    tick(1);
    chk("bne_nt_pc", dut.pc_r, 32'h0000_1004);
    tick(1);
    chk("jal_x1", dut.regs_r[1], 32'h0000_1008);
    chk("jal_pc", dut.pc_r, 32'h0000_1014);

    // BEQ taken, then JALR with bit-0 clear.
    restart(jalr(5'd4, 5'd3, 12'd0), addi(5'd3, 5'd0, 12'h181), 32'h0, enc_b(3'b000, 5'd0, 5'd0, 13'd8));
    tick(1);
    chk("beq_t_pc", dut.pc_r, 32'h0000_1008);
    tick(2);
    chk("jalr_x4", dut.regs_r[4], 32'h0000_1010);
    chk("jalr_pc", dut.pc_r, 32'h0000_0180);

    // Misaligned JALR target traps with cause 0 and no link write.
    restart(32'h0, 32'h0, jalr(5'd4, 5'd3, 12'd0), addi(5'd3, 5'd0, 12'h102));
    tick(2);
    chk("jalr_mis_pc", dut.pc_r, 32'h0000_2000);
    chk("jalr_mis_epc", dut.epc_r, 32'h0000_1004);
    chk("jalr_mis_cause", dut.cause_r, 32'd0);
    chk("jalr_mis_x4", dut.regs_r[4], 32'h0);

    // All-zero boot and handler lines.
    restart(32'h0, 32'h0, 32'h0, 32'h0);
    tick(1);
    chk("illegal_pc", dut.pc_r, 32'h0000_2000);
    chk("illegal_epc", dut.epc_r, 32'h0000_1000);
    chk("illegal_cause", dut.cause_r, 32'd2);
    tick(1);
    chk("loop_pc", dut.pc_r, 32'h0000_2000);
    chk("loop_epc", dut.epc_r, 32'h0000_2000);
    chk("loop_cause", dut.cause_r, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
